regfile_mp: RTL and testbench

Parametrised multi-port integer register file, successor to the single-write/dual-read core register file. It adds configurable depth and port counts, multi-port write priority with write-first bypass on every read port, a pending-write scoreboard for hazard detection, and a sequential clear engine. The clear engine zeroes the array after reset or on request, so the storage itself needs no reset and maps onto RAM/LUT-RAM. It sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - bus bundle between issue/writeback and the multi-port register file
interface regfile_mp_if #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRPORTS = 2,
    parameter int NWPORTS = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NWPORTS-1:0]      we_i;
    logic [NWPORTS*AW-1:0]   waddr_i;
    logic [NWPORTS*XLEN-1:0] wdata_i;
    logic [NRPORTS*AW-1:0]   raddr_i;
    logic [NRPORTS*XLEN-1:0] rdata_o;
    logic [NRPORTS-1:0]      busy_o;
    logic                    issue_i;
    logic [AW-1:0]           issue_rd_i;
    logic                    clr_i;
    logic                    ready_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, issue_i, issue_rd_i, clr_i,
        input  rdata_o, busy_o, ready_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, issue_i, issue_rd_i, clr_i,
        output rdata_o, busy_o, ready_o
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-first bypass, pending scoreboard and clear sweep
// Storage has no reset; the clear sweep zeroes it so it can map onto RAM/LUT-RAM.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRPORTS  = 2,
    parameter int NWPORTS  = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk_i,
    input logic         rst_i,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [XLEN-1:0]  regs [NREGS];

    logic                ready;
    logic                issue_ok;
    logic [NWPORTS-1:0]  wr_ok;
    logic [AW-1:0]       waddr [NWPORTS];
    logic [XLEN-1:0]     wdata [NWPORTS];
    logic [AW-1:0]       raddr [NRPORTS];
    logic [XLEN-1:0]     rd_val [NRPORTS];
    logic [NRPORTS-1:0]  rd_hit;

    assign ready       = (state_q == IDLE);
    assign bus.ready_o = ready;
    assign issue_ok    = ready && bus.issue_i && !(ZR && bus.issue_rd_i == '0);

    always_comb begin
        for (int k = 0; k < NWPORTS; k++) begin
            waddr[k] = bus.waddr_i[k*AW +: AW];
            wdata[k] = bus.wdata_i[k*XLEN +: XLEN];
            wr_ok[k] = ready && bus.we_i[k] && !(ZR && waddr[k] == '0);
        end
        for (int p = 0; p < NRPORTS; p++) begin
            raddr[p] = bus.raddr_i[p*AW +: AW];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                if (bus.clr_i) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == AW'(NREGS - 1)) state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.clr_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Issue is applied after the write clears so a same-cycle new producer keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < NWPORTS; k++) begin
            if (wr_ok[k]) pend_d[waddr[k]] = 1'b0;
        end
        if (issue_ok) pend_d[bus.issue_rd_i] = 1'b1;
        if (ready && bus.clr_i) pend_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Ascending port order makes the highest-index port win on address collisions.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                regs[idx_q] <= '0;
            end else begin
                for (int k = 0; k < NWPORTS; k++) begin
                    if (wr_ok[k]) regs[waddr[k]] <= wdata[k];
                end
            end
        end
    end

    always_comb begin
        bus.rdata_o = '0;
        bus.busy_o  = '0;
        for (int p = 0; p < NRPORTS; p++) begin
            rd_hit[p] = 1'b0;
            rd_val[p] = regs[raddr[p]];
            for (int k = 0; k < NWPORTS; k++) begin
                if (bus.we_i[k] && waddr[k] == raddr[p]) begin
                    rd_hit[p] = 1'b1;
                    rd_val[p] = wdata[k];
                end
            end
            if (ready && !(ZR && raddr[p] == '0)) begin
                bus.rdata_o[p*XLEN +: XLEN] = rd_val[p];
                bus.busy_o[p]               = pend_q[raddr[p]] && !rd_hit[p];
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and randomized bench for regfile_mp against a reference model
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int NWP   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRP), .NWPORTS(NWP)) bus ();

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRP), .NWPORTS(NWP), .ZERO_REG(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Model: register contents, pending set, and edges left before the array is usable.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    int              clear_left = NREGS;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic zero_all();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] ev;
        bit              eb, hit;
        chk("ready", 64'(bus.ready_o), 64'(clear_left == 0));
        for (int p = 0; p < NRP; p++) begin
            ra  = bus.raddr_i[p*AW +: AW];
            ev  = '0;
            eb  = 1'b0;
            hit = 1'b0;
            if (clear_left == 0 && ra != 0) begin
                ev = m_regs[ra];
                for (int k = 0; k < NWP; k++) begin
                    if (bus.we_i[k] && bus.waddr_i[k*AW +: AW] == ra) begin
                        hit = 1'b1;
                        ev  = bus.wdata_i[k*XLEN +: XLEN];
                    end
                end
                eb = m_pend[ra] && !hit;
            end
            chk($sformatf("rdata%0d[r%0d]", p, ra), 64'(bus.rdata_o[p*XLEN +: XLEN]), 64'(ev));
            chk($sformatf("busy%0d[r%0d]", p, ra), 64'(bus.busy_o[p]), 64'(eb));
        end
    endtask

    task automatic model_edge();
        logic [AW-1:0] a;
        if (rst) begin
            clear_left = NREGS;
            zero_all();
        end else if (clear_left > 0) begin
            clear_left = bus.clr_i ? NREGS : clear_left - 1;
        end else begin
            for (int k = 0; k < NWP; k++) begin
                a = bus.waddr_i[k*AW +: AW];
                if (bus.we_i[k] && a != 0) begin
                    m_regs[a] = bus.wdata_i[k*XLEN +: XLEN];
                    m_pend[a] = 1'b0;
                end
            end
            if (bus.issue_i && bus.issue_rd_i != 0) m_pend[bus.issue_rd_i] = 1'b1;
            if (bus.clr_i) begin
                clear_left = NREGS;
                zero_all();
            end
        end
    endtask

    task automatic cycle(input bit do_chk = 1'b1);
        @(negedge clk);
        if (do_chk) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.we_i = '0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0;
        bus.issue_i = 1'b0; bus.issue_rd_i = '0; bus.clr_i = 1'b0;
    endtask

    task automatic set_w(input int k, input bit en, input int addr, input logic [XLEN-1:0] data);
        bus.we_i[k] = en;
        bus.waddr_i[k*AW +: AW] = AW'(addr);
        bus.wdata_i[k*XLEN +: XLEN] = data;
    endtask

    task automatic set_r(input int p, input int addr);
        bus.raddr_i[p*AW +: AW] = AW'(addr);
    endtask

    task automatic wait_ready(input string tag, input int exp_len);
        int cnt = 0;
        while (bus.ready_o !== 1'b1 && cnt < 100) begin
            cycle();
            cnt++;
        end
        chk(tag, 64'(cnt), 64'(exp_len));
    endtask

    task automatic read_all();
        for (int i = 0; i < NREGS; i += NRP) begin
            for (int p = 0; p < NRP; p++) set_r(p, i + p);
            cycle();
        end
    endtask

    initial begin
        idle_inputs();
        zero_all();

        // Reset held two cycles, then a full sweep.
        rst = 1'b1;
        cycle(1'b0);
        cycle();
        rst = 1'b0;
        wait_ready("reset_sweep_len", NREGS);
        read_all();

        // Write with same-cycle bypass, then stored value, then register 0.
        set_w(0, 1, 5, 32'hDEADBEEF); set_r(0, 5); #1;
        chk("bypass_r5", 64'(bus.rdata_o[0 +: XLEN]), 64'h0000_0000_DEAD_BEEF);
        cycle();
        set_w(0, 0, 0, '0); #1;
        chk("stored_r5", 64'(bus.rdata_o[0 +: XLEN]), 64'h0000_0000_DEAD_BEEF);
        cycle();
        set_w(0, 1, 0, 32'hFFFF_FFFF); set_r(0, 0); cycle();
        set_w(0, 0, 0, '0); #1;
        chk("zero_reg", 64'(bus.rdata_o[0 +: XLEN]), 64'h0);
        cycle();

        // Both ports write register 7: port 1 wins.
        set_w(0, 1, 7, 32'h11); set_w(1, 1, 7, 32'h22); set_r(0, 7); #1;
        chk("dual_bypass_r7", 64'(bus.rdata_o[0 +: XLEN]), 64'h22);
        cycle();
        idle_inputs(); set_r(0, 7); #1;
        chk("dual_stored_r7", 64'(bus.rdata_o[0 +: XLEN]), 64'h22);
        cycle();

        // Scoreboard set, clear by write, and issue winning over same-cycle write.
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd3; set_r(1, 3); cycle();
        bus.issue_i = 1'b0; #1;
        chk("busy_after_issue", 64'(bus.busy_o[1]), 64'h1);
        cycle();
        set_w(0, 1, 3, 32'h33); #1;
        chk("busy_write_same_cycle", 64'(bus.busy_o[1]), 64'h0);
        cycle();
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd3; cycle();
        idle_inputs(); set_r(1, 3); #1;
        chk("busy_issue_beats_write", 64'(bus.busy_o[1]), 64'h1);
        cycle();

        // Fill regs 1..31, mark some pending, then clear sweep with a dropped write.
        for (int r = 1; r < NREGS; r += 2) begin
            set_w(0, 1, r, 32'hA5A5A5A5);
            set_w(1, r + 1 < NREGS, (r + 1) % NREGS, 32'hA5A5A5A5);
            cycle();
        end
        idle_inputs();
        bus.issue_i = 1'b1; bus.issue_rd_i = 5'd9; cycle();
        idle_inputs(); bus.clr_i = 1'b1; cycle();
        bus.clr_i = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        set_w(0, 1, 12, 32'h1234_5678); cycle();
        idle_inputs();
        wait_ready("clr_sweep_len", NREGS - 11);
        read_all();
        set_r(0, 9); #1;
        chk("pend_cleared_r9", 64'(bus.busy_o[0]), 64'h0);
        cycle();

        // Reset at idx 10 of a clear sweep restarts the sweep.
        bus.clr_i = 1'b1; cycle();
        bus.clr_i = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        wait_ready("rst_mid_sweep_len", NREGS);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < NWP; k++) begin
                set_w(k, ($urandom % 3) == 0,
                      ($urandom % 4 == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7),
                      ($urandom % 2) ? $urandom : XLEN'($urandom_range(0, 15)));
            end
            for (int p = 0; p < NRP; p++) begin
                set_r(p, ($urandom % 4 == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
            end
            bus.issue_i    = ($urandom % 4) == 0;
            bus.issue_rd_i = AW'($urandom_range(0, 7));
            bus.clr_i      = ($urandom % 300) == 0;
            rst            = ($urandom % 700) == 0;
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
